// File: rtl/hack_cpu.sv
//------------------------------------------------------------------------------
// hack_cpu : 16-bit Hack CPU core (A/D/PC registers, ALU, decode, jump logic)
// Revision : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module hack_cpu (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] inM,
  input  logic [15:0] instruction,
  output logic [15:0] outM,
  output logic        writeM,
  output logic [15:0] addressM,
  output logic [15:0] pc
);

  logic [15:0] a_q, a_d;
  logic [15:0] d_q, d_d;
  logic [15:0] pc_q, pc_d;

  logic        is_c;
  logic        sel_m;
  logic        zx, nx, zy, ny, fn, no;
  logic        dst_a, dst_d, dst_m;
  logic        j_lt, j_eq, j_gt;
  logic [15:0] alu_x, alu_y, alu_f, alu_out;
  logic        zr, ng;
  logic        jump;

  always_comb begin
    is_c  = instruction[15];
    sel_m = instruction[12];
    zx    = instruction[11];
    nx    = instruction[10];
    zy    = instruction[9];
    ny    = instruction[8];
    fn    = instruction[7];
    no    = instruction[6];
    dst_a = instruction[5];
    dst_d = instruction[4];
    dst_m = instruction[3];
    j_lt  = instruction[2];
    j_eq  = instruction[1];
    j_gt  = instruction[0];
  end

  // ALU operates on pre-edge register values; result feeds outM and A/D loads
  always_comb begin
    alu_x = zx ? 16'h0000 : d_q;
    alu_x = nx ? ~alu_x : alu_x;
    alu_y = zy ? 16'h0000 : (sel_m ? inM : a_q);
    alu_y = ny ? ~alu_y : alu_y;
    alu_f = fn ? (alu_x + alu_y) : (alu_x & alu_y);
    alu_out = no ? ~alu_f : alu_f;
    zr = (alu_out == 16'h0000);
    ng = alu_out[15];
  end

  always_comb begin
    jump = is_c & ((j_lt & ng) | (j_eq & zr) | (j_gt & ~ng & ~zr));
    a_d  = a_q;
    d_d  = d_q;
    if (!is_c) begin
      a_d = instruction;
    end else begin
      if (dst_a) a_d = alu_out;
      if (dst_d) d_d = alu_out;
    end
    pc_d = jump ? a_q : (pc_q + 16'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q  <= 16'h0000;
      d_q  <= 16'h0000;
      pc_q <= 16'h0000;
    end else begin
      a_q  <= a_d;
      d_q  <= d_d;
      pc_q <= pc_d;
    end
  end

  assign outM     = alu_out;
  assign writeM   = is_c & dst_m;
  assign addressM = a_q;
  assign pc       = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_hack_cpu.sv
//------------------------------------------------------------------------------
// tb_hack_cpu : directed self-checking bench for hack_cpu
// Revision    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_hack_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] inM = 16'h0000;
  logic [15:0] instruction = 16'h0000;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] addressM;
  logic [15:0] pc;

  int n_checks = 0;
  int n_errors = 0;

  hack_cpu dut (
    .clk         (clk),
    .reset       (reset),
    .inM         (inM),
    .instruction (instruction),
    .outM        (outM),
    .writeM      (writeM),
    .addressM    (addressM),
    .pc          (pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Present an instruction mid-cycle, let combinational outputs settle
  task automatic issue(input logic [15:0] ins, input logic [15:0] m);
    @(negedge clk);
    instruction = ins;
    inM = m;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [15:0] exp_pc;
  logic [7:0]  jmask;
  logic [15:0] dval;
  logic [15:0] dins;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pc", pc, 16'd0);
    chk("reset_addr", addressM, 16'd0);

    @(negedge clk);
    instruction = 16'h3039;
    reset = 1'b0;
    #1;
    chk("ainstr_writeM", {15'd0, writeM}, 16'd0);
    tick();
    chk("ainstr_addr", addressM, 16'd12345);
    chk("ainstr_pc", pc, 16'd1);

    issue(16'hEC10, 16'd0);             // D=A
    chk("DeqA_out", outM, 16'd12345);
    tick();
    chk("DeqA_pc", pc, 16'd2);

    issue(16'h5BA0, 16'd0); tick();     // @23456
    chk("a23456", addressM, 16'd23456);

    issue(16'hE1F0, 16'd11111);         // AD=A-D
    chk("ADeqAmD_out", outM, 16'd11111);
    tick();
    chk("ADeqAmD_addr", addressM, 16'd11111);
    chk("ADeqAmD_pc", pc, 16'd4);

    issue(16'h03EB, 16'd0); tick();     // @1003
    issue(16'hE308, 16'd0);             // M=D
    chk("MeqD_wr", {15'd0, writeM}, 16'd1);
    chk("MeqD_out", outM, 16'd11111);
    chk("MeqD_addr", addressM, 16'd1003);
    tick();

    issue(16'h03EC, 16'd0); tick();     // @1004
    issue(16'hE398, 16'd0);             // MD=D-1
    chk("MDeqDm1_wr", {15'd0, writeM}, 16'd1);
    chk("MDeqDm1_out", outM, 16'd11110);
    chk("MDeqDm1_addr", addressM, 16'd1004);
    tick();
    chk("MDeqDm1_pc", pc, 16'd8);

    issue(16'h03E8, 16'd0); tick();     // @1000
    issue(16'hF4F0, 16'd11111);         // AD=D-M
    chk("ADeqDmM_out", outM, 16'hFFFF);
    tick();
    chk("ADeqDmM_addr", addressM, 16'hFFFF);
    chk("ADeqDmM_pc", pc, 16'd10);

    issue(16'h000E, 16'd0); tick();     // @14
    chk("a14", addressM, 16'd14);
    exp_pc = 16'd11;

    // D;Jxx sweep for D = -1, 0, 1 (jjj bit k set in mask => jumps)
    for (int s = 0; s < 3; s++) begin
      case (s)
        0: begin dval = 16'hFFFF; dins = 16'h0000; jmask = 8'b1111_0000; end
        1: begin dval = 16'h0000; dins = 16'hEA90; jmask = 8'b1100_1100; end
        default: begin dval = 16'h0001; dins = 16'hEFD0; jmask = 8'b1010_1010; end
      endcase
      if (dins != 16'h0000) begin
        issue(dins, 16'd0); tick();
        exp_pc = exp_pc + 16'd1;
      end
      for (int j = 1; j < 8; j++) begin
        issue(16'hE300 | 16'(j), 16'd0);
        chk($sformatf("jmp_out_d%0d_j%0d", s, j), outM, dval);
        chk($sformatf("jmp_wr_d%0d_j%0d", s, j), {15'd0, writeM}, 16'd0);
        tick();
        exp_pc = jmask[j] ? 16'd14 : exp_pc + 16'd1;
        chk($sformatf("jmp_pc_d%0d_j%0d", s, j), pc, exp_pc);
      end
    end

    issue(16'hE7E7, 16'd0);             // A=D+1;JMP with D=1, A=14
    tick();
    chk("dA_jmp_pc", pc, 16'd14);
    chk("dA_jmp_addr", addressM, 16'd2);

    issue(16'hEEA0, 16'd0); tick();     // A=-1
    issue(16'hEA87, 16'd0); tick();     // 0;JMP
    chk("jmp_ffff", pc, 16'hFFFF);
    issue(16'h0005, 16'd0); tick();
    chk("pc_wrap", pc, 16'h0000);
    chk("wrap_addr", addressM, 16'd5);

    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_pc", pc, 16'd0);
    chk("async_rst_addr", addressM, 16'd0);
    tick();
    chk("rst_hold_pc", pc, 16'd0);
    @(negedge clk);
    instruction = 16'h7FFF;
    reset = 1'b0;
    tick();
    chk("restart_pc", pc, 16'd1);
    chk("restart_addr", addressM, 16'd32767);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
